// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: master identifiers, the
// registered response descriptor and the full byte-enable constant.
package sp_ram_arbiter_pkg;

  typedef enum logic {
    MASTER_INSTR = 1'b0,
    MASTER_DATA  = 1'b1
  } master_e;

  typedef struct packed {
    logic    valid;
    master_e master;
    logic    err;
    logic    is_read;
  } resp_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone requester always wins, on conflict the
// master not granted last wins. Index 0 is instr, index 1 is data.
module rr_arb2
  import sp_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  master_e last_q, last_d;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    case (req_i)
      2'b01:   gnt_o[0] = 1'b1;
      2'b10:   gnt_o[1] = 1'b1;
      2'b11: begin
        if (last_q == MASTER_INSTR) gnt_o[1] = 1'b1;
        else                        gnt_o[0] = 1'b1;
      end
      default: ;
    endcase
    if (gnt_o[0])      last_d = MASTER_INSTR;
    else if (gnt_o[1]) last_d = MASTER_DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= MASTER_INSTR;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Arbitrates instr fetch and LSU ports onto one single-port word RAM with range
// checking. Define SP_RAM_ARBITER_RDATA_REG_EN to add a registered response stage.
module sp_ram_arbiter
  import sp_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  data_req_i,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam logic [31:0] WINDOW = 32'(NUM_WORDS) << 2;

  logic [1:0]            req, gnt;
  logic [31:0]           instr_off, data_off;
  logic                  instr_in, data_in, sel_in, any_gnt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  resp_t                 resp_q, resp_d, out_resp;
  logic [31:0]           out_rdata;

  // Requests are masked by reset so grants drop asynchronously with rst_n.
  assign req = {data_req_i, instr_req_i} & {2{rst_n}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign instr_off = instr_addr_i - BASE_ADDR;
  assign data_off  = data_addr_i - BASE_ADDR;
  assign instr_in  = instr_off < WINDOW;
  assign data_in   = data_off < WINDOW;
  assign any_gnt   = |gnt;
  assign sel_in    = gnt[1] ? data_in : instr_in;

  assign instr_gnt_o = gnt[0];
  assign data_gnt_o  = gnt[1];

  always_comb begin
    addr_d         = gnt[1] ? data_off[ADDR_WIDTH+1:2] : instr_off[ADDR_WIDTH+1:2];
    resp_d.valid   = any_gnt;
    resp_d.master  = gnt[1] ? MASTER_DATA : MASTER_INSTR;
    resp_d.err     = any_gnt & ~sel_in;
    resp_d.is_read = any_gnt & sel_in & ~(gnt[1] & data_we_i);
  end

  assign ram_en_o    = any_gnt & sel_in;
  assign ram_we_o    = ram_en_o & gnt[1] & data_we_i;
  assign ram_be_o    = gnt[1] ? data_be_i : BE_ALL;
  assign ram_wdata_o = data_wdata_i;
  assign ram_addr_o  = ram_en_o ? addr_d : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      resp_q <= '0;
    end else begin
      if (ram_en_o) addr_q <= addr_d;
      resp_q <= resp_d;
    end
  end

`ifdef SP_RAM_ARBITER_RDATA_REG_EN
  resp_t       resp2_q;
  logic [31:0] rdata2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp2_q  <= '0;
      rdata2_q <= '0;
    end else begin
      resp2_q  <= resp_q;
      rdata2_q <= resp_q.is_read ? ram_rdata_i : '0;
    end
  end

  assign out_resp  = resp2_q;
  assign out_rdata = resp2_q.is_read ? rdata2_q : '0;
`else
  assign out_resp  = resp_q;
  assign out_rdata = resp_q.is_read ? ram_rdata_i : '0;
`endif

  assign instr_rvalid_o = out_resp.valid & (out_resp.master == MASTER_INSTR);
  assign data_rvalid_o  = out_resp.valid & (out_resp.master == MASTER_DATA);
  assign instr_err_o    = instr_rvalid_o & out_resp.err;
  assign data_err_o     = data_rvalid_o & out_resp.err;
  assign instr_rdata_o  = instr_rvalid_o ? out_rdata : '0;
  assign data_rdata_o   = data_rvalid_o ? out_rdata : '0;

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Arbitrates two PULPino-style master ports onto one single-port word RAM: an instruction fetch port (read-only, master 0) and an LSU data port (read/write, master 1).
- Sits directly upstream of the sp_ram instance and drives its en/addr/wdata/we/be.
- Captures the RAM's 1-cycle read data and returns it on the winning master's rvalid.
- Performs a base/size range check and answers out-of-range requests with an error response, without touching the RAM.

Parameters:
- ADDR_WIDTH, 8, RAM word-address width; must match the sp_ram instance.
- NUM_WORDS, 256, RAM depth in 32-bit words; must be ≤ 2**ADDR_WIDTH.
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be NUM_WORDS*4 aligned.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch range error, qualified by rvalid
- data_req_i  in  1  LSU request
- data_addr_i  in  32  LSU byte address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  LSU grant
- data_rvalid_o  out  1  LSU response valid; writes also get one
- data_rdata_o  out  32  LSU read data
- data_err_o  out  1  LSU range error, qualified by rvalid
- ram_en_o  out  1  RAM enable
- ram_addr_o  out  ADDR_WIDTH  RAM word address
- ram_wdata_o  out  32  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  4  RAM byte enables
- ram_rdata_i  in  32  RAM read data, valid 1 cycle after ram_en_o

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt/rvalid/err outputs 0; rdata outputs 32'h0.
  - ram_en_o 0; last_grant = MASTER_INSTR, so data wins the first conflict.
  - An outstanding response is dropped; no rvalid is emitted after reset deasserts.
- Grant:
  - Combinational, same cycle as req. At most one of instr_gnt_o/data_gnt_o is high per cycle.
  - A single requester always wins.
  - Both requesting: round-robin, so the master not granted last wins.
  - last_grant updates only on an actual grant.
- Addressing:
  - in_range = (addr - BASE_ADDR) < NUM_WORDS*4, computed in 32-bit unsigned arithmetic so wrap below BASE_ADDR counts as out of range.
  - ram_addr_o = (addr - BASE_ADDR)[ADDR_WIDTH+1:2]; addr[1:0] ignored.
- Granted, in-range request:
  - ram_en_o = 1 in the grant cycle.
  - Instr: ram_we_o = 0, ram_be_o = 4'hF.
  - Data: we/be/wdata passed through.
- Granted, out-of-range request:
  - Grant is still given, but ram_en_o = 0.
  - Response in the next cycle: err = 1, rdata = 0.
- Response:
  - Exactly one cycle after grant, the granted master's rvalid = 1 for one cycle.
  - rdata = ram_rdata_i for in-range reads, 32'h0 for writes or errors.
  - err = 0 when in range.
- Pipelining: a new grant is allowed in the same cycle as the previous response (throughput of 1 access/cycle).
- State (registered):
  - resp_valid, resp_master (0 = instr, 1 = data), resp_err, resp_is_read, last_grant.
- Idle cycles: ram_en_o = 0. ram_addr_o holds its previous value; it is don't-care.
- Write then read of the same word on back-to-back cycles returns the new data, because sp_ram writes on the edge before the read.

Optional Feature:
- Macro: SP_RAM_ARBITER_RDATA_REG_EN.
- With the macro: response data is registered one extra cycle.
  - rvalid/rdata/err appear 2 cycles after grant.
  - A 2-deep response shift register preserves 1 access/cycle throughput.
  - Reset clears both stages.
- Without the macro: 1-cycle latency as above, with rdata driven combinationally from ram_rdata_i.

Decomposition:
- Package sp_ram_arbiter_pkg:
  - typedef enum logic {MASTER_INSTR, MASTER_DATA} master_e.
  - struct resp_t {valid, master, err, is_read}.
  - localparam BE_ALL = 4'hF.
- Sub-module rr_arb2: 2-input round-robin arbiter with last-grant register (clk, rst_n, req[1:0], gnt[1:0]).
- Response pipeline stays inline.

Test Plan:
- Data write then read:
  - Data write addr 0x10, wdata 0xDEADBEEF, be 4'hF, then read 0x10.
  - Expect data_gnt_o same cycle each time.
  - Expect data_rvalid_o 1 cycle later each time; second rdata = 0xDEADBEEF, err = 0.
- Byte-enable write:
  - Word 0x20 holds 0x11223344; write be = 4'b0010, wdata 0x0000AA00; read back.
  - Expect 0x1122AA44.
- Simultaneous requests:
  - instr and data both request continuously for 4 cycles out of reset.
  - Expect grants D,I,D,I.
  - Expect rvalid on the matching port each following cycle; no cycle with both gnt high.
- Out of range:
  - Data read at BASE_ADDR + NUM_WORDS*4 (0x400 by default); also instr read at BASE_ADDR - 4 with BASE_ADDR = 0x1000.
  - Expect gnt, ram_en_o = 0, rvalid next cycle with err = 1, rdata = 0.
- Reset mid-operation:
  - Assert rst_n low in the cycle after a grant.
  - Expect all rvalid/gnt = 0 immediately (async).
  - Expect no response after release; the first conflict after release is granted to data.
- Macro on (SP_RAM_ARBITER_RDATA_REG_EN):
  - Back-to-back instr reads of 0x0, 0x4, 0x8.
  - Expect rvalid at grant+2 on 3 consecutive cycles, with data in order.
